// File: rtl/empty_and_readpointer_pkg.sv
// Shared dual-clock FIFO definitions: default address width and the Gray/binary
// pointer conversions used by both the read and write control blocks.
package empty_and_readpointer_pkg;

  localparam int ADDRSIZE_DEFAULT = 5;

  // Conversions work on a wide word; callers zero-extend and size-cast back.
  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/empty_and_readpointer_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock.
module two_flop_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs at the same edge and the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/empty_and_readpointer.sv
// Read-side control of the dual-clock FIFO: read pointer, registered empty flag,
// read-side occupancy and almost-empty status.
module empty_and_readpointer
  import empty_and_readpointer_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEFAULT,
  parameter int AE_THRESH = 2
) (
  input  logic                read_clk,
  input  logic                read_rst,
  input  logic                clear,
  input  logic                read_enable,
  input  logic [ADDRSIZE:0]   write_ptr,
  output logic                empty,
  output logic [ADDRSIZE-1:0] read_addr,
  output logic [ADDRSIZE:0]   read_ptr,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                almost_empty
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

  logic [PW-1:0] write_ptr_sync;
  logic [PW-1:0] read_bin;
  logic [PW-1:0] read_bin_next;
  logic [PW-1:0] read_gray_next;
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] level_next;
  logic          pop;
  logic          empty_val;
  logic          almost_empty_val;

  two_flop_sync #(
    .WIDTH(PW)
  ) u_wptr_sync (
    .clk  (read_clk),
    .rst_n(read_rst),
    .d    (write_ptr),
    .q    (write_ptr_sync)
  );

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    pop              = read_enable & ~empty;
    read_bin_next    = read_bin + PW'(pop);
    read_gray_next   = PW'(bin2gray(ptr_word_t'(read_bin_next)));
    wbin_sync        = PW'(gray2bin(ptr_word_t'(write_ptr_sync)));
    // Comparing against the post-pop pointer lets the last pop raise empty with no bubble.
    empty_val        = (read_gray_next == write_ptr_sync);
    level_next       = wbin_sync - read_bin_next;
    almost_empty_val = (level_next <= AE_LEVEL);
  end

  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      read_bin     <= '0;
      read_ptr     <= '0;
      empty        <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else if (clear) begin
      read_bin     <= '0;
      read_ptr     <= '0;
      empty        <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      read_bin     <= read_bin_next;
      read_ptr     <= read_gray_next;
      empty        <= empty_val;
      rd_level     <= level_next;
      almost_empty <= almost_empty_val;
    end
  end

  assign read_addr = read_bin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_empty_and_readpointer.sv
// Directed bench for empty_and_readpointer: integer occupancy model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_empty_and_readpointer;

  localparam int AW = 5;
  localparam int PW = 6;
  localparam int AE = 2;

  logic          read_clk    = 1'b0;
  logic          read_rst    = 1'b0;
  logic          clear       = 1'b0;
  logic          read_enable = 1'b0;
  logic [PW-1:0] write_ptr;
  logic          empty;
  logic [AW-1:0] read_addr;
  logic [PW-1:0] read_ptr;
  logic [PW-1:0] rd_level;
  logic          almost_empty;

  int wcount   = 0;   // binary write count; the DUT sees its Gray code
  int checks   = 0;
  int failures = 0;

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = v[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  assign write_ptr = to_gray(wcount);

  empty_and_readpointer #(
    .ADDRSIZE (AW),
    .AE_THRESH(AE)
  ) dut (
    .read_clk    (read_clk),
    .read_rst    (read_rst),
    .clear       (clear),
    .read_enable (read_enable),
    .write_ptr   (write_ptr),
    .empty       (empty),
    .read_addr   (read_addr),
    .read_ptr    (read_ptr),
    .rd_level    (rd_level),
    .almost_empty(almost_empty)
  );

  always #5 read_clk = ~read_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: write count seen two edges late; occupancy is plain count arithmetic.
  int m_s1 = 0, m_s2 = 0, m_rb = 0, m_level = 0;
  bit m_empty = 1'b1, m_ae = 1'b1;
  int m_pop, m_rbn, m_lvl;

  assign m_pop = (read_enable && !m_empty) ? 1 : 0;
  assign m_rbn = (m_rb + m_pop) % 64;
  assign m_lvl = (m_s2 - m_rbn + 64) % 64;

  always @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      m_s1 <= 0; m_s2 <= 0; m_rb <= 0;
      m_empty <= 1'b1; m_level <= 0; m_ae <= 1'b1;
    end else begin
      m_s1 <= wcount % 64;
      m_s2 <= m_s1;
      if (clear) begin
        m_rb <= 0; m_empty <= 1'b1; m_level <= 0; m_ae <= 1'b1;
      end else begin
        m_rb    <= m_rbn;
        m_level <= m_lvl;
        m_empty <= (m_lvl == 0);
        m_ae    <= (m_lvl <= AE);
      end
    end
  end

  always @(negedge read_clk) begin
    check("cmp_empty", 32'(empty),        32'(m_empty));
    check("cmp_addr",  32'(read_addr),    m_rb % 32);
    check("cmp_ptr",   32'(read_ptr),     32'(to_gray(m_rb)));
    check("cmp_level", 32'(rd_level),     m_level);
    check("cmp_ae",    32'(almost_empty), 32'(m_ae));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge read_clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, 32'(empty),        32'd1);
    check({tag, "_ae"},    32'(almost_empty), 32'd1);
    check({tag, "_ptr"},   32'(read_ptr),     32'd0);
    check({tag, "_addr"},  32'(read_addr),    32'd0);
    check({tag, "_level"}, 32'(rd_level),     32'd0);
  endtask

  initial begin
    // Reset held
    tick(2);
    check_reset_values("rst");
    read_rst = 1'b1;
    tick(1);

    // Single word: empty falls on the third edge, one pop empties it again
    wcount = 1;
    tick(2);
    check("sw_empty_edge2", 32'(empty), 32'd1);
    tick(1);
    check("sw_empty_edge3", 32'(empty),        32'd0);
    check("sw_level",       32'(rd_level),     32'd1);
    check("sw_ae",          32'(almost_empty), 32'd1);
    read_enable = 1'b1;
    tick(1);
    read_enable = 1'b0;
    check("sw_pop_addr",  32'(read_addr), 32'd1);
    check("sw_pop_ptr",   32'(read_ptr),  32'b000001);
    check("sw_pop_empty", 32'(empty),     32'd1);

    // Underflow guard
    read_rst = 1'b0;
    wcount   = 0;
    tick(1);
    read_rst    = 1'b1;
    read_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("uf_addr", 32'(read_addr), 32'd0);
      check("uf_ptr",  32'(read_ptr),  32'd0);
    end
    read_enable = 1'b0;

    // Full occupancy, then drain down to the almost-empty threshold
    wcount = 32;
    tick(3);
    check("full_level", 32'(rd_level),     32'd32);
    check("full_ae",    32'(almost_empty), 32'd0);
    check("full_empty", 32'(empty),        32'd0);
    read_enable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 29) begin
        check("ae_level3", 32'(rd_level),     32'd3);
        check("ae_off",    32'(almost_empty), 32'd0);
      end
    end
    read_enable = 1'b0;
    check("ae_level2", 32'(rd_level),     32'd2);
    check("ae_on",     32'(almost_empty), 32'd1);
    check("ae_addr",   32'(read_addr),    32'd30);

    // Wrap: write count 33, pops 31..33 cross the address wrap
    wcount = 33;
    tick(3);
    check("wrap_level", 32'(rd_level), 32'd3);
    read_enable = 1'b1;
    tick(1);
    check("wrap_addr31", 32'(read_addr), 32'd31);
    tick(1);
    check("wrap_addr0",  32'(read_addr), 32'd0);
    check("wrap_ptr32",  32'(read_ptr),  32'b110000);
    check("wrap_empty0", 32'(empty),     32'd0);
    tick(1);
    check("wrap_addr1",  32'(read_addr), 32'd1);
    check("wrap_ptr33",  32'(read_ptr),  32'b110001);
    check("wrap_empty1", 32'(empty),     32'd1);
    tick(2);
    check("wrap_hold", 32'(read_addr), 32'd1);
    read_enable = 1'b0;

    // Pop coinciding with a synchronised pointer update
    wcount = 36;
    tick(3);
    wcount = 38;
    read_enable = 1'b1;
    tick(3);
    read_enable = 1'b0;
    check("coinc_level", 32'(rd_level), 32'd2);
    check("coinc_addr",  32'(read_addr), 32'd4);
    check("coinc_empty", 32'(empty),     32'd0);

    // Asynchronous reset mid-stream at level 5
    wcount = 41;
    tick(3);
    check("mid_level5", 32'(rd_level), 32'd5);
    #2;
    read_rst = 1'b0;
    wcount   = 0;
    #1;
    check_reset_values("midrst");
    tick(1);
    read_rst = 1'b1;
    tick(1);

    // Clear wins over a simultaneous pop, then flags recompute
    wcount = 5;
    tick(3);
    check("clr_pre_level", 32'(rd_level), 32'd5);
    clear       = 1'b1;
    read_enable = 1'b1;
    tick(1);
    clear       = 1'b0;
    read_enable = 1'b0;
    check_reset_values("clr");
    tick(1);
    check("clr_after_empty", 32'(empty),        32'd0);
    check("clr_after_level", 32'(rd_level),     32'd5);
    check("clr_after_ae",    32'(almost_empty), 32'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
